// File: rtl/fp_adder.sv
// fp_adder: IEEE-754 single-precision adder, one-cycle registered result.
// Define FP_ADDER_RNE_EN for round-to-nearest-even; default is truncate.
module fp_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        out_valid,
    output logic [31:0] out
);

`ifdef FP_ADDER_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic found;
        lzc27 = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      lzc27 = lzc27 + 5'd1;
            end
        end
    endfunction

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        swap;

    assign sa = src1[31];
    assign sb = src2[31];
    assign ea = src1[30:23];
    assign eb = src2[30:23];
    assign fa = src1[22:0];
    assign fb = src2[22:0];

    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    // Raw exponent:fraction compare orders finite normal magnitudes.
    assign swap = src2[30:0] > src1[30:0];

    logic        big_s;
    logic [7:0]  big_e, sml_e, diff;
    logic [23:0] big_m, sml_m;
    logic [53:0] wide;
    logic [26:0] big_x, sml_x, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_r;
    logic        rnd_up;
    logic [24:0] rmant;
    logic [22:0] frac;
    logic [31:0] res;
    logic [31:0] out_d, out_q;
    logic        vld_d, vld_q;

    // Align, add/subtract, normalize, round and select specials.
    always_comb begin
        big_s = swap ? sb : sa;
        big_e = swap ? eb : ea;
        sml_e = swap ? ea : eb;
        big_m = swap ? {1'b1, fb} : {1'b1, fa};
        sml_m = swap ? {1'b1, fa} : {1'b1, fb};
        diff  = big_e - sml_e;
        wide  = {sml_m, 3'b000, 27'd0} >> diff;
        if (diff >= 8'd26) sml_x = 27'd1;
        else sml_x = {wide[53:28], wide[27] | (|wide[26:0])};
        big_x = {big_m, 3'b000};
        if (sa == sb) sum = {1'b0, big_x} + {1'b0, sml_x};
        else          sum = {1'b0, big_x} - {1'b0, sml_x};
        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, big_e} + 10'd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = {2'b00, big_e} - {5'd0, lz};
        end
        rnd_up = RNE & norm[2] & (norm[1] | norm[0] | norm[3]);
        rmant  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        exp_r  = exp_n + {9'd0, rmant[24]};
        frac   = rmant[24] ? rmant[23:1] : rmant[22:0];

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            res = QNAN;
        else if (a_inf)
            res = src1;
        else if (b_inf)
            res = src2;
        else if (a_zero && b_zero)
            res = {sa & sb, 31'd0};
        else if (a_zero)
            res = src2;
        else if (b_zero)
            res = src1;
        else if (sum == 28'd0)
            res = 32'd0;
        else if (exp_n[9] || (exp_n == 10'd0))
            res = {big_s, 31'd0};
        else if (exp_r >= 10'd255)
            res = RNE ? {big_s, 8'hFF, 23'd0} : {big_s, 8'hFE, 23'h7F_FFFF};
        else
            res = {big_s, exp_r[7:0], frac};
    end

    // Capture a new sum when valid; otherwise hold data and drop valid.
    always_comb begin
        out_d = in_valid ? res : out_q;
        vld_d = in_valid;
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 32'd0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_fp_adder.sv
// tb_fp_adder: directed vector table plus reset and hold sequences.
// Expected values follow the rounding mode chosen by FP_ADDER_RNE_EN.
module tb_fp_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic [31:0] out;

    int errs;
    int checks;

    fp_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .src1     (src1),
        .src2     (src2),
        .out_valid(out_valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
`ifdef FP_ADDER_RNE_EN
        logic [31:0] rnd_y = 32'h3F80_0001;
        logic [31:0] ovf_y = 32'h7F80_0000;
`else
        logic [31:0] rnd_y = 32'h3F80_0000;
        logic [31:0] ovf_y = 32'h7F7F_FFFF;
`endif
        errs   = 0;
        checks = 0;

        vecs[0]  = '{"neg_add",   32'hC080_0000, 32'hC040_0000, 32'hC0E0_0000};
        vecs[1]  = '{"mix_sub",   32'h40A0_0000, 32'hC040_0000, 32'h4000_0000};
        vecs[2]  = '{"neg_big",   32'hC080_0000, 32'h4000_0000, 32'hC000_0000};
        vecs[3]  = '{"cancel",    32'h4040_0000, 32'hC040_0000, 32'h0000_0000};
        vecs[4]  = '{"tie_even",  32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        vecs[5]  = '{"round_up",  32'h3F80_0000, 32'h33C0_0000, rnd_y};
        vecs[6]  = '{"inf_minf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
        vecs[7]  = '{"nan_in",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000};
        vecs[8]  = '{"inf_fin",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000};
        vecs[9]  = '{"sub_pzmz",  32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        vecs[10] = '{"overflow",  32'h7F7F_FFFF, 32'h7F7F_FFFF, ovf_y};
        vecs[11] = '{"mz_mz",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vecs[12] = '{"zero_pass", 32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000};
        vecs[13] = '{"underflow", 32'h0080_0000, 32'h8080_0001, 32'h8000_0000};
        vecs[14] = '{"carry",     32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
        vecs[15] = '{"ninf_fin",  32'hFF80_0000, 32'hBF80_0000, 32'hFF80_0000};
        vecs[16] = '{"subn_pass", 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        src1     = 32'd0;
        src2     = 32'd0;
        #1;
        chk("rst_out", out, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_vld", {31'd0, out_valid}, 32'd0);
        chk("idle_out", out, 32'd0);

        // Back-to-back vectors, one per cycle.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            src1     = vecs[i].a;
            src2     = vecs[i].b;
            @(posedge clk);
            #1;
            chk(vecs[i].name, out, vecs[i].y);
            chk({vecs[i].name, "_vld"}, {31'd0, out_valid}, 32'd1);
        end

        // in_valid low: data holds, valid drops.
        @(negedge clk);
        in_valid = 1'b0;
        src1     = 32'h4040_0000;
        src2     = 32'h4040_0000;
        @(posedge clk);
        #1;
        chk("hold_out", out, 32'h3F80_0000);
        chk("hold_vld", {31'd0, out_valid}, 32'd0);

        // Reset mid-run clears outputs immediately.
        @(negedge clk);
        in_valid = 1'b1;
        src1     = 32'hC080_0000;
        src2     = 32'hC040_0000;
        @(posedge clk);
        #1;
        chk("pre_rst_out", out, 32'hC0E0_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 32'd0);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("post_rst_out", out, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fp_adder.md
Name: fp_adder

Overview:
- IEEE-754 single-precision floating-point adder; the add path of the floating-point ALU.
- Takes two 32-bit operands (src1, src2) and produces the registered 32-bit sum one clock later.
- Purely feed-forward: no stall or backpressure. A valid bit travels alongside the data.

Parameters:
- None. Format is fixed: 1 sign, 8 exponent, 23 fraction, bias 127.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  src1/src2 are sampled this cycle
- src1  input  32  operand A, IEEE-754 single
- src2  input  32  operand B, IEEE-754 single
- out_valid  output  1  out holds a new result
- out  output  32  registered sum src1+src2, IEEE-754 single

Behaviour:
- Reset (rst_n low, asynchronous): out=32'h0000_0000, out_valid=0. Both hold until the first rising edge after rst_n deasserts.
- Latency and handshake:
  - Exactly 1 cycle; full throughput, one operation per cycle.
  - Rising edge with in_valid=1: out <= sum(src1,src2), out_valid <= 1.
  - Rising edge with in_valid=0: out holds its value, out_valid <= 0.
- Reset mid-operation: the in-flight result is discarded; outputs return to reset values immediately.
- Datapath steps, all combinational before the output register:
  1. Unpack; the hidden 1 is prepended for normal operands.
  2. Compare magnitudes (exponent, then mantissa) and swap so A is the larger magnitude.
  3. Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. Shifts of 26 or more leave only sticky.
  4. Effective add when signs are equal; otherwise subtract the smaller from the larger.
  5. Carry-out: shift right 1 and increment the exponent.
  6. Otherwise normalize with a leading-zero count: shift left and decrement the exponent.
  7. Round per the rounding mode (Optional Feature). A rounding carry renormalizes and increments the exponent.
- Result sign:
  - Normally the sign of the larger-magnitude operand.
  - Exact cancellation (x + -x) gives +0.
  - (-0)+(-0) gives -0; (+0)+(-0) gives +0.
- Subnormals:
  - Inputs with exponent 0 are treated as signed zero (flush-to-zero).
  - A result whose exponent underflows below 1 is flushed to signed zero.
- Zero operand: the result is the other operand, bit-exact, except for the zero-sign rules above.
- Special values:
  - Any NaN input gives canonical quiet NaN 32'h7FC0_0000.
  - +Inf + -Inf gives 32'h7FC0_0000.
  - Inf + finite gives that Inf; Inf + same-sign Inf gives that Inf.
- Overflow (biased exponent reaches 255 after rounding): ±Inf (32'h7F80_0000 / 32'hFF80_0000) in RNE mode; ±max-finite (32'h7F7F_FFFF / 32'hFF7F_FFFF) in truncate mode.
- No exception flags are output.

Optional Feature:
- Macro: FP_ADDER_RNE_EN.
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky.
- Not defined: round toward zero (truncate; guard/round/sticky discarded).
- All other behaviour is identical in both modes, including specials and flush-to-zero.

Test Plan:
- Reset: assert rst_n=0 mid-run -> out=32'h0, out_valid=0 immediately. After release, in_valid=0 keeps out_valid=0.
- Same-sign add: -4.0 + -3.0 (C080_0000 + C040_0000) -> out=C0E0_0000 (-7.0), out_valid=1 one cycle later. Back-to-back 5.0 + -3.0 (40A0_0000 + C040_0000) -> 4000_0000 (2.0) on the following cycle.
- Subtract / cancel: -4.0 + 2.0 (C080_0000 + 4000_0000) -> C000_0000 (-2.0). 3.0 + -3.0 (4040_0000 + C040_0000) -> 0000_0000 (+0).
- Rounding: 1.0 + 2^-24 (3F80_0000 + 3380_0000) -> 3F80_0000 (tie to even). 1.0 + 1.5*2^-24 (3F80_0000 + 33C0_0000) -> 3F80_0001 with FP_ADDER_RNE_EN; 3F80_0000 without.
- Specials: 7F80_0000 + FF80_0000 -> 7FC0_0000. 7FC0_0001 + 3F80_0000 -> 7FC0_0000. 7F80_0000 + 3F80_0000 -> 7F80_0000. 0000_0001 + 8000_0000 -> 0000_0000.
- Overflow: 7F7F_FFFF + 7F7F_FFFF -> 7F80_0000 with FP_ADDER_RNE_EN; 7F7F_FFFF without.
